// File: rtl/jk_pkg.sv
// Shared mode encodings and the single-bit JK next-state function for the
// jk_reg_bank datapath.
package jk_pkg;

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // JK truth table: hold, clear, set, toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with synchronous active-low reset, parallel load and enable.
// Priority: RESET > LOAD > EN > JK.
module jk_cell
    import jk_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic RESET_BIT,
    input  logic EN,
    input  logic LOAD,
    input  logic D,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_d;
    logic q_q;

    // NOTE: q_d gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (LOAD) begin
            q_d = D;
        end else if (EN) begin
            q_d = jk_next(q_q, J, K);
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank / up-down counter with load, TC and EVT outputs.
// Optional macro JK_SATURATE_EN: counting holds at all-ones / zero instead of wrapping.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int                WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             EVT
);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] q_next;
    logic             all_ones;
    logic             all_zero;
    logic             sat;
    logic             evt_d;
    logic             evt_q;

    assign all_ones = &q_bits;
    assign all_zero = ~|q_bits;

`ifdef JK_SATURATE_EN
    assign sat = ((MODE == MODE_UP) && all_ones) || ((MODE == MODE_DN) && all_zero);
`else
    assign sat = 1'b0;
`endif

    // Cascaded toggle enables and the per-bit J/K mode mux.
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        j_eff   = '0;
        k_eff   = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q_bits[i-1];
            t_dn[i] = t_dn[i-1] & ~q_bits[i-1];
        end
        case (MODE)
            MODE_JK: begin
                j_eff = J;
                k_eff = K;
            end
            MODE_UP: begin
                j_eff = sat ? '0 : t_up;
                k_eff = sat ? '0 : t_up;
            end
            MODE_DN: begin
                j_eff = sat ? '0 : t_dn;
                k_eff = sat ? '0 : t_dn;
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
    end

    // Mirror of the cells' next state, used only to detect a change for EVT.
    always_comb begin
        q_next = q_bits;
        for (int i = 0; i < WIDTH; i++) begin
            if (LOAD) begin
                q_next[i] = D[i];
            end else if (EN) begin
                q_next[i] = jk_next(q_bits[i], j_eff[i], k_eff[i]);
            end
        end
        evt_d = (q_next != q_bits);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .CLK      (CLK),
            .RESET    (RESET),
            .RESET_BIT(RESET_VAL[g]),
            .EN       (EN),
            .LOAD     (LOAD),
            .D        (D[g]),
            .J        (j_eff[g]),
            .K        (k_eff[g]),
            .Q        (q_bits[g])
        );
    end

    assign Q   = q_bits;
    assign TC  = EN && !LOAD && (((MODE == MODE_UP) && all_ones) || ((MODE == MODE_DN) && all_zero));
    assign EVT = evt_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: arithmetic reference model compared every
// cycle, plus directed literal expectations.
module tb_jk_reg_bank;

    localparam int W = 4;
    localparam logic [W-1:0] MAXV = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0;
    logic [W-1:0] k = '0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         evt;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_q;
    logic         m_evt;
    logic         m_valid = 1'b0;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL('0)) dut (
        .CLK  (clk),
        .RESET(reset),
        .EN   (en),
        .MODE (mode),
        .J    (j),
        .K    (k),
        .LOAD (load),
        .D    (d),
        .Q    (q),
        .TC   (tc),
        .EVT  (evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: JK via set/clear/toggle masks, counting via +/- arithmetic.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] cur);
        logic [W-1:0] set_m, clr_m, tog_m;
        if (load) return d;
        if (!en) return cur;
        case (mode)
            2'd0: begin
                set_m = j & ~k;
                clr_m = ~j & k;
                tog_m = j & k;
                return ((cur | set_m) & ~clr_m) ^ tog_m;
            end
`ifdef JK_SATURATE_EN
            2'd1: return (cur == MAXV) ? cur : W'(cur + 1);
            2'd2: return (cur == 0) ? cur : W'(cur - 1);
`else
            2'd1: return W'(cur + 1);
            2'd2: return W'(cur - 1);
`endif
            default: return cur;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] nxt;
        if (!reset) begin
            m_q     = '0;
            m_evt   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            nxt   = model_next(m_q);
            m_evt = (nxt != m_q);
            m_q   = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("q_model", 32'(q), 32'(m_q));
            check("evt_model", 32'(evt), 32'(m_evt));
            check("tc_model", 32'(tc),
                  32'(en && !load && ((mode == 2'd1 && m_q == MAXV) || (mode == 2'd2 && m_q == 0))));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset two cycles while counting up
        reset = 1'b0; en = 1'b1; mode = 2'b01;
        tick; tick;
        check("reset_q", 32'(q), 32'h0);
        check("reset_evt", 32'(evt), 32'h0);
        reset = 1'b1;
        tick; check("count_1", 32'(q), 32'h1);
        check("count_evt", 32'(evt), 32'h1);
        tick; check("count_2", 32'(q), 32'h2);
        tick; check("count_3", 32'(q), 32'h3);

        // Per-bit JK from 0011
        mode = 2'b00; j = 4'b1010; k = 4'b0110;
        tick; check("jk_q", 32'(q), 32'h9);
        check("jk_evt", 32'(evt), 32'h1);
        j = 4'b0000; k = 4'b0000;
        tick; check("jk_hold_q", 32'(q), 32'h9);
        check("jk_hold_evt", 32'(evt), 32'h0);

        // Wrap / saturate at all-ones
        load = 1'b1; d = 4'b1110;
        check("tc_load_blocks", 32'(tc), 32'h0);
        tick; check("load_1110", 32'(q), 32'hE);
        load = 1'b0; mode = 2'b01;
        check("tc_up_low", 32'(tc), 32'h0);
        tick; check("up_1111", 32'(q), 32'hF);
        check("tc_up", 32'(tc), 32'h1);
        tick;
`ifdef JK_SATURATE_EN
        check("up_sat_q", 32'(q), 32'hF);
        check("up_sat_evt", 32'(evt), 32'h0);
`else
        check("up_wrap_q", 32'(q), 32'h0);
        check("up_wrap_evt", 32'(evt), 32'h1);
`endif

        // Count down through zero
        load = 1'b1; d = 4'b0001; mode = 2'b10;
        tick; load = 1'b0;
        tick; check("dn_0000", 32'(q), 32'h0);
        check("tc_dn", 32'(tc), 32'h1);
        tick;
`ifdef JK_SATURATE_EN
        check("dn_sat_q", 32'(q), 32'h0);
`else
        check("dn_wrap_q", 32'(q), 32'hF);
`endif
        en = 1'b0;
        check("tc_en_low", 32'(tc), 32'h0);
        tick; tick;
`ifdef JK_SATURATE_EN
        check("en_hold_q", 32'(q), 32'h0);
`else
        check("en_hold_q", 32'(q), 32'hF);
`endif
        check("en_hold_evt", 32'(evt), 32'h0);

        // Load with EN=0, then reset beats load
        load = 1'b1; d = 4'b0101; mode = 2'b01;
        tick; check("load_en0", 32'(q), 32'h5);
        reset = 1'b0;
        tick; check("reset_over_load", 32'(q), 32'h0);

        // Mid-count reset
        reset = 1'b1; en = 1'b1; d = 4'b0110;
        tick; load = 1'b0;
        check("pre_mid_q", 32'(q), 32'h6);
        reset = 1'b0;
        tick; check("mid_reset_q", 32'(q), 32'h0);
        check("mid_reset_evt", 32'(evt), 32'h0);
        reset = 1'b1;
        tick; check("resume_q", 32'(q), 32'h1);

        // Equal-value load gives no event; MODE 11 holds
        load = 1'b1; d = 4'b0001;
        tick; check("load_equal_evt", 32'(evt), 32'h0);
        load = 1'b0; mode = 2'b11;
        tick; check("mode11_q", 32'(q), 32'h1);

        // JK pattern sweep checked by the model
        mode = 2'b00;
        for (int i = 0; i < 16; i++) begin
            j = W'(i);
            k = W'((i * 5 + 3) & 15);
            tick;
        end
        mode = 2'b10;
        for (int i = 0; i < 6; i++) tick;

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
